// File: rtl/washer_plant_model.sv
// Plant model for the automatic washing machine controller.
// Turns actuator commands into water level, dosing and timer sensor
// responses, and latches a sticky fault on illegal actuator combinations.
// All outputs are decoded from registered state only.
module washer_plant_model #(
    parameter int LEVEL_MAX   = 8,
    parameter int DET_CYCLES  = 4,
    parameter int WASH_CYCLES = 16,
    parameter int SPIN_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               door_lock,
    input  logic                               motor_on,
    input  logic                               fill_value_on,
    input  logic                               drain_value_on,
    input  logic                               soap_wash,
    input  logic                               water_wash,
    input  logic                               done,
    output logic                               filled,
    output logic                               drained,
    output logic                               detergent_added,
    output logic                               cycle_timeout,
    output logic                               spin_timeout,
    output logic                               fault,
    output logic [$clog2(LEVEL_MAX+1)-1:0]     level
);

    localparam int LVL_W  = $clog2(LEVEL_MAX + 1);
    localparam int DET_W  = $clog2(DET_CYCLES + 2);
    localparam int WASH_W = $clog2(WASH_CYCLES + 2);
    localparam int SPIN_W = $clog2(SPIN_CYCLES + 2);

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(LEVEL_MAX);
    localparam logic [DET_W-1:0]  DET_TERM  = DET_W'(DET_CYCLES);
    localparam logic [DET_W-1:0]  DET_LAST  = DET_W'(DET_CYCLES - 1);
    localparam logic [WASH_W-1:0] WASH_TERM = WASH_W'(WASH_CYCLES);
    localparam logic [WASH_W-1:0] WASH_LAST = WASH_W'(WASH_CYCLES - 1);
    localparam logic [SPIN_W-1:0] SPIN_TERM = SPIN_W'(SPIN_CYCLES);
    localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'(SPIN_CYCLES - 1);

    logic [DET_W-1:0]  det_cnt;
    logic [WASH_W-1:0] wash_cnt;
    logic [SPIN_W-1:0] spin_cnt;
    logic              fill_prev_p1;

    logic fault_trig;
    logic fill_rise;
    logic det_qual;
    logic wash_qual;
    logic spin_qual;
    logic level_full;
    logic level_empty;

    // Rinse water flag is informational; the plant reacts only to valves and motor.
    logic unused_water_wash;
    assign unused_water_wash = water_wash;

    // Saturating level update: fill raises, drain lowers, both or neither hold.
    function automatic logic [LVL_W-1:0] level_step(input logic [LVL_W-1:0] lvl,
                                                    input logic fill_on,
                                                    input logic drain_on);
        logic [LVL_W-1:0] nxt;
        nxt = lvl;
        if (fill_on && !drain_on && lvl != LVL_FULL) begin
            nxt = lvl + 1'b1;
        end else if (drain_on && !fill_on && lvl != '0) begin
            nxt = lvl - 1'b1;
        end
        return nxt;
    endfunction

    assign level_full  = (level == LVL_FULL);
    assign level_empty = (level == '0);

    assign fault_trig = (fill_value_on && drain_value_on) || (motor_on && !door_lock);
    assign fill_rise  = fill_value_on && !fill_prev_p1;
    assign det_qual   = soap_wash && door_lock && level_full;
    assign wash_qual  = motor_on && door_lock && !drain_value_on && level_full;
    assign spin_qual  = motor_on && door_lock && drain_value_on && level_empty;

    assign filled  = level_full;
    assign drained = level_empty;

    // Plant state: reset, then sticky fault freeze, then done, then phase restart, then counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            level           <= '0;
            det_cnt         <= '0;
            wash_cnt        <= '0;
            spin_cnt        <= '0;
            fill_prev_p1    <= 1'b0;
            detergent_added <= 1'b0;
            cycle_timeout   <= 1'b0;
            spin_timeout    <= 1'b0;
            fault           <= 1'b0;
        end else if (fault || fault_trig) begin
            fault <= 1'b1;
        end else begin
            fill_prev_p1 <= fill_value_on;
            if (done) begin
                det_cnt         <= '0;
                wash_cnt        <= '0;
                spin_cnt        <= '0;
                detergent_added <= 1'b0;
                cycle_timeout   <= 1'b0;
                spin_timeout    <= 1'b0;
            end else begin
                level <= level_step(level, fill_value_on, drain_value_on);

                if (det_qual && det_cnt != DET_TERM) begin
                    det_cnt <= det_cnt + 1'b1;
                end
                if (det_qual && det_cnt == DET_LAST) begin
                    detergent_added <= 1'b1;
                end

                if (fill_rise) begin
                    wash_cnt      <= '0;
                    spin_cnt      <= '0;
                    cycle_timeout <= 1'b0;
                    spin_timeout  <= 1'b0;
                end else begin
                    if (wash_qual && wash_cnt != WASH_TERM) begin
                        wash_cnt <= wash_cnt + 1'b1;
                    end
                    if (wash_qual && wash_cnt == WASH_LAST) begin
                        cycle_timeout <= 1'b1;
                    end
                    if (spin_qual && spin_cnt != SPIN_TERM) begin
                        spin_cnt <= spin_cnt + 1'b1;
                    end
                    if (spin_qual && spin_cnt == SPIN_LAST) begin
                        spin_timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_washer_plant_model.sv
// Self-checking bench for washer_plant_model: directed scenarios followed by
// random actuator traffic, all compared against a count-based reference model.
module tb_washer_plant_model;

    localparam int LM = 4;
    localparam int DC = 2;
    localparam int WC = 5;
    localparam int SC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       door_lock = 1'b0;
    logic       motor_on = 1'b0;
    logic       fill_value_on = 1'b0;
    logic       drain_value_on = 1'b0;
    logic       soap_wash = 1'b0;
    logic       water_wash = 1'b0;
    logic       done = 1'b0;
    logic       filled;
    logic       drained;
    logic       detergent_added;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       fault;
    logic [2:0] level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integer counts; a flag is simply "count reached N".
    int m_level = 0;
    int m_det = 0;
    int m_wash = 0;
    int m_spin = 0;
    bit m_fault = 0;
    bit m_fill_prev = 0;

    washer_plant_model #(
        .LEVEL_MAX(LM), .DET_CYCLES(DC), .WASH_CYCLES(WC), .SPIN_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
        .filled(filled), .drained(drained), .detergent_added(detergent_added),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
        .fault(fault), .level(level)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input bit lk, input bit mo, input bit fi,
                              input bit dr, input bit so, input bit dn);
        int lvl;
        if (r) begin
            m_level = 0; m_det = 0; m_wash = 0; m_spin = 0;
            m_fault = 0; m_fill_prev = 0;
        end else if (m_fault || (fi && dr) || (mo && !lk)) begin
            m_fault = 1;
        end else begin
            lvl = m_level;
            if (dn) begin
                m_det = 0; m_wash = 0; m_spin = 0;
            end else begin
                if (fi) m_level = (lvl + 1 > LM) ? LM : lvl + 1;
                else if (dr) m_level = (lvl - 1 < 0) ? 0 : lvl - 1;
                if (so && lk && lvl == LM) m_det++;
                if (fi && !m_fill_prev) begin
                    m_wash = 0; m_spin = 0;
                end else begin
                    if (mo && lk && !dr && lvl == LM) m_wash++;
                    if (mo && lk && dr && lvl == 0) m_spin++;
                end
            end
            m_fill_prev = fi;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit lk, input bit mo, input bit fi,
                        input bit dr, input bit so, input bit dn);
        reset = r; door_lock = lk; motor_on = mo; fill_value_on = fi;
        drain_value_on = dr; soap_wash = so; done = dn;
        water_wash = $urandom_range(0, 1);
        @(posedge clk);
        model_edge(r, lk, mo, fi, dr, so, dn);
        #1;
        vectors++;
        chk("level", 32'(level), m_level);
        chk("filled", 32'(filled), 32'(m_level == LM));
        chk("drained", 32'(drained), 32'(m_level == 0));
        chk("detergent_added", 32'(detergent_added), 32'(m_det >= DC));
        chk("cycle_timeout", 32'(cycle_timeout), 32'(m_wash >= WC));
        chk("spin_timeout", 32'(spin_timeout), 32'(m_spin >= SC));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    initial begin
        bit r, lk, mo, fi, dr, so, dn;
        int v;

        // Reset and fill
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_drained", 32'(drained), 1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("fill1_drained", 32'(drained), 0);
        chk("fill1_filled", 32'(filled), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        chk("fill4_level", 32'(level), 4);
        chk("fill4_filled", 32'(filled), 1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("fill5_sat", 32'(level), 4);

        // Full program
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 1, 0);
        chk("prog_det", 32'(detergent_added), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("prog_wash4", 32'(cycle_timeout), 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("prog_wash5", 32'(cycle_timeout), 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0, 0);
        chk("prog_drained", 32'(drained), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 0);
        chk("prog_spin", 32'(spin_timeout), 1);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("done_det", 32'(detergent_added), 0);
        chk("done_ct", 32'(cycle_timeout), 0);
        chk("done_st", 32'(spin_timeout), 0);
        chk("done_level", 32'(level), 0);

        // Pause and rinse restart
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("pause_6th", 32'(cycle_timeout), 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("pause_7th", 32'(cycle_timeout), 1);
        step(0, 1, 0, 1, 0, 0, 0);
        chk("restart_ct", 32'(cycle_timeout), 0);
        chk("restart_det", 32'(detergent_added), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("rinse_ct", 32'(cycle_timeout), 1);
        chk("rinse_det", 32'(detergent_added), 1);

        // Faults
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("fault_valves", 32'(fault), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0);
        chk("fault_frozen_level", 32'(level), 2);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("fault_reset", 32'(fault), 0);
        chk("fault_reset_level", 32'(level), 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("fault_door", 32'(fault), 1);

        // Done on the edge where spin would reach terminal count
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 1, 0, 1);
        chk("simul_st", 32'(spin_timeout), 0);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 1, 0, 0);
        chk("simul_cnt_cleared", 32'(spin_timeout), 0);
        step(0, 1, 1, 0, 1, 0, 0);
        chk("simul_recount", 32'(spin_timeout), 1);

        // Drain saturation at empty
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("sat_level", 32'(level), 0);
        chk("sat_drained", 32'(drained), 1);
        chk("sat_fault", 32'(fault), 0);

        // Random actuator traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) < 3);
            lk = ($urandom_range(0, 99) >= 3);
            mo = ($urandom_range(0, 99) < 40);
            v  = $urandom_range(0, 99);
            fi = (v < 32) || (v >= 98);
            dr = (v >= 65);
            so = ($urandom_range(0, 99) < 40);
            dn = ($urandom_range(0, 99) < 3);
            step(r, lk, mo, fi, dr, so, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
